// File: rtl/ram_stream_port_if.sv
// Purpose: bundles the command, stream and RAM-pin signals of ram_stream_port.
// Latency: none; this is a pure signal bundle.
// Backpressure: carries s_valid/s_ready and m_valid/m_ready, which are handled by the port logic.
// Ports: master = the sequencer view (drives RAM pins, s_ready, m_data/m_valid, busy/done);
//        slave  = the environment view (command, s_data/s_valid, m_ready, ram_do).
interface ram_stream_port_if #(
   parameter int ADDR_BITS = 13,
   parameter int WIDTH     = 8
);
   logic                 start;
   logic                 wr;
   logic [ADDR_BITS-1:0] base;
   logic [ADDR_BITS:0]   len;
   logic                 busy;
   logic                 done;
   logic [WIDTH-1:0]     s_data;
   logic                 s_valid;
   logic                 s_ready;
   logic [WIDTH-1:0]     m_data;
   logic                 m_valid;
   logic                 m_ready;
   logic [ADDR_BITS-1:0] ram_addr;
   logic                 ram_we;
   logic [WIDTH-1:0]     ram_di;
   logic [WIDTH-1:0]     ram_do;

   modport master (
      input  start, wr, base, len, s_data, s_valid, m_ready, ram_do,
      output busy, done, s_ready, m_data, m_valid, ram_addr, ram_we, ram_di
   );

   modport slave (
      output start, wr, base, len, s_data, s_valid, m_ready, ram_do,
      input  busy, done, s_ready, m_data, m_valid, ram_addr, ram_we, ram_di
   );
endinterface

// File: rtl/ram_stream_port.sv
// Purpose: turns a one-shot burst command into consecutive single-port RAM accesses, streaming bytes in/out.
// Latency: write beat lands in the cycle it is accepted; read data appears 2 cycles after start, then 1/cycle.
// Backpressure: s_valid low or m_ready low stalls the burst cycle-for-cycle with no loss or duplication.
// Ports: clk, rst_n (async active-low); io (master modport): start/wr/base/len command, busy/done status,
//        s_* write stream, m_* read stream, ram_addr/ram_we/ram_di/ram_do RAM pins.
module ram_stream_port #(
   parameter int ADDR_BITS = 13,
   parameter int WIDTH     = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   ram_stream_port_if.master  io
);
   typedef enum logic [1:0] {IDLE, WR, RD_WAIT, RD_OUT} state_t;

   localparam logic [ADDR_BITS:0] CNT_ONE = (ADDR_BITS+1)'(1);

   state_t               state_q, state_d;
   logic [ADDR_BITS-1:0] ptr_q, ptr_d;
   logic [ADDR_BITS:0]   cnt_q, cnt_d;
   logic                 done_q, done_d;

   logic [ADDR_BITS-1:0] ptr_inc;
   logic                 s_fire;
   logic                 m_fire;
   logic                 last_beat;
   logic [WIDTH-1:0]     wr_byte;
   logic [WIDTH-1:0]     rd_byte;

   // Address arithmetic wraps modulo 2**ADDR_BITS by truncation.
   assign ptr_inc   = ptr_q + 1'b1;
   assign s_fire    = (state_q == WR) && io.s_valid;
   assign m_fire    = (state_q == RD_OUT) && io.m_ready;
   assign last_beat = (cnt_q == CNT_ONE);
   assign wr_byte   = io.s_data;
   assign rd_byte   = io.ram_do;

   assign io.s_ready = (state_q == WR);
   assign io.ram_we  = s_fire;
   assign io.ram_di  = wr_byte;
   assign io.m_valid = (state_q == RD_OUT);
   assign io.m_data  = rd_byte;
   assign io.busy    = (state_q != IDLE);
   assign io.done    = done_q;
   // On a read handshake the next address is presented early so the RAM's
   // registered read has the following byte ready next cycle (no bubble).
   // While stalled the address is held, keeping ram_do (and m_data) stable.
   assign io.ram_addr = m_fire ? ptr_inc : ptr_q;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (io.start) begin
               ptr_d = io.base;
               cnt_d = io.len;
               if (io.len == '0) begin
                  done_d = 1'b1;
               end else if (io.wr) begin
                  state_d = WR;
               end else begin
                  state_d = RD_WAIT;
               end
            end
         end
         WR: begin
            if (s_fire) begin
               ptr_d = ptr_inc;
               cnt_d = cnt_q - 1'b1;
               if (last_beat) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         RD_WAIT: begin
            // One cycle for the RAM to register base before data is valid.
            state_d = RD_OUT;
         end
         RD_OUT: begin
            if (m_fire) begin
               ptr_d = ptr_inc;
               cnt_d = cnt_q - 1'b1;
               if (last_beat) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end
endmodule

// File: doc/ram_stream_port.md
# ram_stream_port

Sequencing initiator for the single-port `ram` block: converts a one-shot burst command into a run of consecutive RAM accesses. Write bursts take bytes from a valid/ready input stream. Read bursts deliver bytes on a valid/ready output stream. The block sits between stream producers and consumers (loader, DMA, CPU bridge) and the RAM's `we`/`addr`/`di`/`do` pins, and it owns the RAM's one-cycle registered-address read latency.

## Interface
- `ADDR_BITS`, 13, RAM address width; the address space is 2**ADDR_BITS bytes.
- `WIDTH`, 8, data width; must match the RAM's `WIDTH`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  command strobe; sampled only in IDLE.
- `wr`  in  1  command direction: 1 = write burst (stream → RAM), 0 = read burst (RAM → stream).
- `base`  in  ADDR_BITS  first address of the burst.
- `len`  in  ADDR_BITS+1  beat count, 0 to 2**ADDR_BITS.
- `busy`  out  1  high while a burst is in progress.
- `done`  out  1  one-cycle pulse after the last beat of a burst.
- `s_data`/`s_valid`/`s_ready`  in/in/out  WIDTH/1/1  write-data stream.
- `m_data`/`m_valid`/`m_ready`  out/out/in  WIDTH/1/1  read-data stream.
- `ram_addr`  out  ADDR_BITS  drives RAM `addr`.
- `ram_we`  out  1  drives RAM `we`.
- `ram_di`  out  WIDTH  drives RAM `di`.
- `ram_do`  in  WIDTH  from RAM `do`; reflects the address registered on the previous edge.

## Operation
- **Registers:**
  - `state`: IDLE, WR, RD_WAIT, RD_OUT.
  - `ptr`: ADDR_BITS wide.
  - `cnt`: ADDR_BITS+1 wide.
  - `done`: registered output.
- **IDLE:**
  - `start`=1 latches `ptr`←`base` and `cnt`←`len`.
  - `len`=0: stay in IDLE and pulse `done` next cycle. No RAM access.
  - Otherwise go to WR if `wr`=1, else RD_WAIT.
  - `start` is ignored outside IDLE.
- **WR:**
  - `s_ready`=1.
  - A beat transfers when `s_valid`=1. That cycle: `ram_we`=1, `ram_addr`=`ptr`, `ram_di`=`s_data`.
  - On each beat: `ptr`←`ptr`+1, `cnt`←`cnt`−1.
  - The beat with `cnt`=1 returns the block to IDLE and pulses `done`.
  - `ram_we` is combinational: `s_valid & s_ready`. It is never 1 outside WR.
- **RD_WAIT:**
  - `ram_addr`=`ptr`, `m_valid`=0.
  - Lasts exactly one cycle, then RD_OUT.
- **RD_OUT:**
  - `m_valid`=1. `m_data`=`ram_do` (combinational pass-through).
  - When `m_ready`=0: `ram_addr` holds `ptr`. The RAM's registered address is unchanged, so `m_data` stays stable while stalled.
  - When `m_ready`=1: `ram_addr`=`ptr`+1 (combinational), `ptr`←`ptr`+1, `cnt`←`cnt`−1. Next cycle's `ram_do` already holds the next byte, so there is no bubble.
  - A handshake with `cnt`=1 returns the block to IDLE and pulses `done`.
- **Address wrap:** all increments are modulo 2**ADDR_BITS. Address 2**ADDR_BITS−1 is followed by 0.
- **Full-memory burst:** `len`=2**ADDR_BITS visits every address once.
- **Port defaults** (whenever not specified above): `s_ready`=0, `m_valid`=0, `ram_we`=0, `ram_di`=`s_data`, `ram_addr`=`ptr`.
- `busy` = (`state` != IDLE).
- **Reset:** asynchronous assertion of `rst_n` at any time forces IDLE, `ptr`=0, `cnt`=0, `done`=0. An in-flight burst is abandoned, and `ram_we` drops immediately. No partial-burst `done` is generated.
- **Reset values:** `busy`=0, `done`=0, `s_ready`=0, `m_valid`=0, `ram_we`=0, `ram_addr`=0.

## Timing
- `start` sampled at edge E → `busy`=1 from E+1.
- **Write burst:** first beat can transfer in cycle E+1. Throughput is 1 beat/cycle with `s_valid` held high. `len`=N with no stalls: last write at E+N, `done`=1 in cycle E+N+1.
- **Read burst:**
  - `ram_addr`=`base` during cycle E+1 (RD_WAIT).
  - `m_valid`=1 with byte[`base`] from E+2.
  - 1 beat/cycle with `m_ready` held high.
  - `len`=N with no stalls: `done`=1 in cycle E+N+2.
- Stalls on either stream extend the burst cycle-for-cycle. No data is lost or duplicated.
- A new `start` is accepted in the same cycle `done` is high, since the block is back in IDLE.

## Test plan
- **Write burst:** reset; write `base`=0x0010, `len`=4, bytes A1,B2,C3,D4 with `s_valid` held high → RAM addresses 0x10–0x13 hold those bytes; `ram_we` high exactly 4 cycles; `done` one cycle after the last beat.
- **Read, no stalls:** read `base`=0x0010, `len`=4, `m_ready`=1 → `m_data` A1,B2,C3,D4 on consecutive cycles starting 2 cycles after `start`; `busy` falls with `done`.
- **Read with backpressure:** same read with `m_ready` toggling 1,0,0,1,1,0,1 → exactly 4 handshakes, in order A1,B2,C3,D4; `m_data` stable during every stall.
- **Wrap-around:** write `base`=0x1FFE, `len`=4, bytes 11,22,33,44, then read back → addresses 0x1FFE, 0x1FFF, 0x0000, 0x0001 hold 11,22,33,44 and read back in that order.
- **Zero length and ignored start:** `len`=0 → `done` pulse, `busy` stays 0, no `ram_we`. A `start` asserted while `busy`=1 does not change the active burst.
- **Reset mid-burst:** assert `rst_n`=0 after 2 beats of a 6-beat write → `ram_we`, `busy` and `s_ready` drop immediately; no `done` is generated; after release the block accepts a new read burst normally.
